// File: rtl/ringosc_meas_ctrl.sv
// Ring-oscillator frequency measurement controller.
// The controller enables the inverter ring, waits for it to settle, and then
// counts rising edges of the asynchronous oscillator output over a window of
// ck cycles. The edge count and a saturation flag stay valid until the next
// accepted start.
module ringosc_meas_ctrl #(
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 12,
  parameter int SETTLE_CYC = 4
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] win,
  input  logic             osc_i,
  output logic             osc_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  // One down-counter times both SETTLE and COUNT, so it has to be wide enough
  // for whichever of the two intervals is longer.
  localparam int TMR_W = (WIN_W > 4) ? WIN_W : 4;
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
  localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_nxt;
  logic [WIN_W-1:0] win_q;
  logic             start_acc;

  logic             sync1;
  logic             sync2;
  logic             hist;
  logic             osc_rise;

  // Two-flop synchronizer for the asynchronous oscillator, plus a history flop
  // so that a rising edge is seen exactly once.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the three flops shift together on
      // the same edge; blocking ones would collapse the chain into one flop.
      sync1 <= osc_i;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign osc_rise = sync2 & ~hist;

  // State and interval-timer register.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  // Next-state logic. The timer is loaded with (length - 1) on entry to a
  // timed state and the state advances on the cycle it reads zero, so SETTLE
  // lasts SETTLE_CYC cycles and COUNT lasts exactly win_q cycles.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so that no path
    // through the case leaves it unassigned, which would infer a latch.
    state_nxt = state;
    tmr_nxt   = tmr;
    start_acc = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          if (win != '0) begin
            state_nxt = SETTLE;
            tmr_nxt   = SETTLE_LD;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      SETTLE: begin
        if (tmr == '0) begin
          state_nxt = COUNT;
          tmr_nxt   = TMR_W'(win_q) - TMR_ONE;
        end else begin
          tmr_nxt = tmr - TMR_ONE;
        end
      end
      COUNT: begin
        if (tmr == '0) begin
          state_nxt = DONE;
        end else begin
          tmr_nxt = tmr - TMR_ONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The window length is captured only when a start is accepted, so later
  // changes on win cannot disturb a measurement that is already running.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      win_q <= '0;
    end else if (start_acc) begin
      win_q <= win;
    end
  end

  // Edge counter with saturation. The result is cleared on the edge that
  // leaves IDLE and otherwise holds until the next accepted start.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (start_acc) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (state == COUNT && osc_rise) begin
      if (&count) begin
        ovf <= 1'b1;
      end else begin
        count <= count + CNT_ONE;
      end
    end
  end

  // Outputs are decoded from the registered state, so an asynchronous reset
  // clears them at once without waiting for a clock edge.
  assign osc_en = (state == SETTLE) || (state == COUNT);
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_ringosc_meas_ctrl.sv
// Directed testbench for ringosc_meas_ctrl. A full-width instance covers the
// nominal, zero-window, busy and reset scenarios; a 4-bit instance driven by
// the same inputs covers counter saturation.
module tb_ringosc_meas_ctrl;

  logic        ck;
  logic        rst;
  logic        start;
  logic [11:0] win;
  logic        osc_i;

  logic        osc_en;
  logic        busy;
  logic        done;
  logic [15:0] count;
  logic        ovf;

  logic        s_osc_en;
  logic        s_busy;
  logic        s_done;
  logic [3:0]  s_count;
  logic        s_ovf;

  int tests = 0;
  int fails = 0;
  int osc_half = 0;

  ringosc_meas_ctrl #(.CNT_W(16), .WIN_W(12), .SETTLE_CYC(4)) dut (
    .ck     (ck),
    .rst    (rst),
    .start  (start),
    .win    (win),
    .osc_i  (osc_i),
    .osc_en (osc_en),
    .busy   (busy),
    .done   (done),
    .count  (count),
    .ovf    (ovf)
  );

  ringosc_meas_ctrl #(.CNT_W(4), .WIN_W(12), .SETTLE_CYC(4)) dut_sat (
    .ck     (ck),
    .rst    (rst),
    .start  (start),
    .win    (win),
    .osc_i  (osc_i),
    .osc_en (s_osc_en),
    .busy   (s_busy),
    .done   (s_done),
    .count  (s_count),
    .ovf    (s_ovf)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Oscillator model: square wave with a half-period of osc_half ck cycles,
  // changing on the falling ck edge; osc_half == 0 holds it low.
  initial begin
    int ph;
    ph    = 0;
    osc_i = 1'b0;
    forever begin
      @(negedge ck);
      if (osc_half == 0) begin
        osc_i = 1'b0;
        ph    = 0;
      end else begin
        ph++;
        if (ph >= osc_half) begin
          ph    = 0;
          osc_i = ~osc_i;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present start for one cycle with window w, then observe n cycles.
  // Cycle 0 is the cycle in which start is high; cycle i is sampled on the
  // falling edge after the i-th rising edge.
  task automatic measure(input logic [11:0] w, input int n,
                         output int done_cnt, output int first_done,
                         output int en_cnt);
    done_cnt   = 0;
    first_done = 0;
    en_cnt     = 0;
    @(negedge ck);
    win   = w;
    start = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(negedge ck);
      start = 1'b0;
      if (done) begin
        done_cnt++;
        if (first_done == 0) first_done = i;
      end
      if (osc_en) en_cnt++;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    win   = '0;
    #3;
    tests++; if (osc_en !== 1'b0) begin fails++; $display("FAIL reset_osc_en got %b want 0", osc_en); end
    tests++; if (busy   !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done   !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (count  !== 16'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    tests++; if (ovf    !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", ovf); end
    @(negedge ck);
    rst = 1'b0;
  endtask

  // Assert reset in the middle of a ck cycle during SETTLE; outputs must
  // clear before the next rising edge.
  task automatic test_reset_async;
    int dc, fd, ec;
    osc_half = 2;
    measure(12'd100, 3, dc, fd, ec);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL async_pre_busy got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    tests++; if (osc_en !== 1'b0) begin fails++; $display("FAIL async_osc_en got %b want 0", osc_en); end
    tests++; if (busy   !== 1'b0) begin fails++; $display("FAIL async_busy got %b want 0", busy); end
    tests++; if (done   !== 1'b0) begin fails++; $display("FAIL async_done got %b want 0", done); end
    @(negedge ck);
    rst = 1'b0;
  endtask

  task automatic test_nominal;
    int dc, fd, ec;
    osc_half = 2;
    measure(12'd100, 120, dc, fd, ec);
    tests++; if (fd !== 105) begin fails++; $display("FAIL nom_done_cycle got %0d want 105", fd); end
    tests++; if (dc !== 1) begin fails++; $display("FAIL nom_done_pulses got %0d want 1", dc); end
    tests++; if (ec !== 104) begin fails++; $display("FAIL nom_osc_en_cycles got %0d want 104", ec); end
    tests++; if (count !== 16'd25) begin fails++; $display("FAIL nom_count got %0d want 25", count); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL nom_ovf got %b want 0", ovf); end
  endtask

  task automatic test_zero_window;
    int dc, fd, ec;
    measure(12'd0, 6, dc, fd, ec);
    tests++; if (fd !== 1) begin fails++; $display("FAIL zero_done_cycle got %0d want 1", fd); end
    tests++; if (dc !== 1) begin fails++; $display("FAIL zero_done_pulses got %0d want 1", dc); end
    tests++; if (ec !== 0) begin fails++; $display("FAIL zero_osc_en_cycles got %0d want 0", ec); end
    tests++; if (count !== 16'd0) begin fails++; $display("FAIL zero_count got %0d want 0", count); end
    tests++; if (s_ovf !== 1'b0) begin fails++; $display("FAIL zero_ovf_clear got %b want 0", s_ovf); end
  endtask

  task automatic test_saturation;
    int dc, fd, ec;
    osc_half = 1;
    measure(12'd40, 50, dc, fd, ec);
    tests++; if (fd !== 45) begin fails++; $display("FAIL sat_done_cycle got %0d want 45", fd); end
    tests++; if (s_count !== 4'd15) begin fails++; $display("FAIL sat_count got %0d want 15", s_count); end
    tests++; if (s_ovf !== 1'b1) begin fails++; $display("FAIL sat_ovf got %b want 1", s_ovf); end
    measure(12'd8, 20, dc, fd, ec);
    tests++; if (s_count !== 4'd4) begin fails++; $display("FAIL sat_next_count got %0d want 4", s_count); end
    tests++; if (s_ovf !== 1'b0) begin fails++; $display("FAIL sat_next_ovf got %b want 0", s_ovf); end
  endtask

  task automatic test_start_while_busy;
    int dc, fd;
    logic b14, b15;
    osc_half = 2;
    dc = 0; fd = 0;
    @(negedge ck);
    win   = 12'd20;
    start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge ck);
      if (i == 1) start = 1'b0;
      if (i == 10) begin start = 1'b1; win = 12'd50; end
      if (i == 11) start = 1'b0;
      if (done) begin dc++; if (fd == 0) fd = i; end
    end
    tests++; if (dc !== 1) begin fails++; $display("FAIL busy_done_pulses got %0d want 1", dc); end
    tests++; if (fd !== 25) begin fails++; $display("FAIL busy_done_cycle got %0d want 25", fd); end
    tests++; if (count !== 16'd5) begin fails++; $display("FAIL busy_count got %0d want 5", count); end

    // Start held high: the second run begins only from IDLE after DONE.
    dc = 0; fd = 0; b14 = 1'bx; b15 = 1'bx;
    @(negedge ck);
    win   = 12'd8;
    start = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge ck);
      if (done) begin dc++; if (fd == 0) fd = i; end
      if (i == 14) b14 = busy;
      if (i == 15) b15 = busy;
    end
    start = 1'b0;
    repeat (20) @(negedge ck);
    tests++; if (fd !== 13) begin fails++; $display("FAIL held_first_done got %0d want 13", fd); end
    tests++; if (dc !== 2) begin fails++; $display("FAIL held_done_pulses got %0d want 2", dc); end
    tests++; if (b14 !== 1'b0) begin fails++; $display("FAIL held_idle_gap got %b want 0", b14); end
    tests++; if (b15 !== 1'b1) begin fails++; $display("FAIL held_rearm got %b want 1", b15); end
  endtask

  task automatic test_midrun_reset;
    int dc, fd, ec;
    osc_half = 2;
    measure(12'd100, 50, dc, fd, ec);
    tests++; if (count < 16'd10) begin fails++; $display("FAIL mid_pre_count got %0d want >= 10", count); end
    #2 rst = 1'b1;
    #1;
    tests++; if (osc_en !== 1'b0) begin fails++; $display("FAIL mid_osc_en got %b want 0", osc_en); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy got %b want 0", busy); end
    tests++; if (count !== 16'd0) begin fails++; $display("FAIL mid_count got %0d want 0", count); end
    @(negedge ck);
    rst = 1'b0;
    dc  = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge ck);
      if (done || busy) dc++;
    end
    tests++; if (dc !== 0) begin fails++; $display("FAIL mid_no_done got %0d active cycles want 0", dc); end
  endtask

  initial begin
    test_reset();
    test_reset_async();
    test_nominal();
    test_zero_window();
    test_saturation();
    test_start_while_busy();
    test_midrun_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
